// File: rtl/adder_fault_sweep_pkg.sv
// Shared types for the adder fault sweep: fault modes, sweep states and
// the helper that picks the next enabled fault mode.
package adder_fault_pkg;

    localparam int NUM_MODES = 4;

    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_SA0  = 2'd1,
        MODE_SA1  = 2'd2,
        MODE_FLIP = 2'd3
    } fault_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DONE   = 3'd4
    } sweep_state_e;

    // Lowest enabled mode whose index is >= from. Bit 2 says whether one
    // exists, bits 1:0 carry the mode index.
    function automatic logic [2:0] find_mode(input logic [NUM_MODES-1:0] mask,
                                             input logic [2:0]           from);
        logic [2:0] res;
        res = 3'b000;
        for (int m = NUM_MODES - 1; m >= 0; m--) begin
            if (mask[m] && (3'(m) >= from)) begin
                res = {1'b1, 2'(m)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/adder_fault_sweep_inject.sv
// Combinational WIDTH-bit adder with a single-bit fault injected on the
// selected sum bit. A fault_bit beyond the sum MSB matches no bit, so the
// sum passes through untouched.
module adder_fault_inject
    import adder_fault_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int FBW   = $clog2(WIDTH + 2)
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  fault_mode_e      i_mode,
    input  logic [FBW-1:0]   i_fault_bit,
    output logic [WIDTH:0]   o_golden,
    output logic [WIDTH:0]   o_sum
);

    // Full-width sum: the carry out is kept, nothing is truncated.
    assign o_golden = {1'b0, i_a} + {1'b0, i_b};

    generate
        for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_bit
            logic w_hit;
            assign w_hit = (i_fault_bit == FBW'(gi));
            assign o_sum[gi] = !w_hit                 ? o_golden[gi] :
                               (i_mode == MODE_SA0)   ? 1'b0 :
                               (i_mode == MODE_SA1)   ? 1'b1 :
                               (i_mode == MODE_FLIP)  ? ~o_golden[gi] :
                                                        o_golden[gi];
        end
    endgenerate

endmodule

// File: rtl/adder_fault_sweep.sv
// Adder fault sweep: walks every (a, b) pair across the enabled fault
// modes, compares faulty and golden sums and streams one record per vector
// over valid/ready. Define ADDER_FAULT_SWEEP_ABORT_EN to add the abort input.
module adder_fault_sweep
    import adder_fault_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NUM_MODES-1:0]         mode_mask,
    input  logic [$clog2(WIDTH+2)-1:0]   fault_bit,
`ifdef ADDER_FAULT_SWEEP_ABORT_EN
    input  logic                         abort,
`endif
    output logic                         busy,
    output logic                         done,
    output logic                         rec_valid,
    input  logic                         rec_ready,
    output logic [WIDTH-1:0]             rec_a,
    output logic [WIDTH-1:0]             rec_b,
    output logic [1:0]                   rec_mode,
    output logic [WIDTH:0]               rec_sum,
    output logic [WIDTH:0]               rec_golden,
    output logic                         rec_mismatch,
    output logic [2*WIDTH+2:0]           mismatch_cnt
);

    localparam int FBW = $clog2(WIDTH + 2);
    localparam int CW  = 2 * WIDTH + 3;
    // Settle counter runs 0..SETTLE-1.
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    sweep_state_e         r_state, w_state_next;
    logic [NUM_MODES-1:0] r_mask;
    logic [FBW-1:0]       r_fault_bit;
    logic [WIDTH-1:0]     r_a, r_b;
    fault_mode_e          r_mode;
    logic [SCW-1:0]       r_settle_cnt;
    logic                 r_done;
    logic [WIDTH-1:0]     r_rec_a, r_rec_b;
    fault_mode_e          r_rec_mode;
    logic [WIDTH:0]       r_rec_sum, r_rec_golden;
    logic                 r_rec_mismatch;
    logic [CW-1:0]        r_mismatch_cnt;

    logic [WIDTH:0]       w_sum, w_golden;
    logic [2:0]           w_first_in, w_first_latched, w_next_mode;
    logic                 w_abort, w_active, w_handshake, w_last;

`ifdef ADDER_FAULT_SWEEP_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    adder_fault_inject #(
        .WIDTH (WIDTH),
        .FBW   (FBW)
    ) u_inject (
        .i_a         (r_a),
        .i_b         (r_b),
        .i_mode      (r_mode),
        .i_fault_bit (r_fault_bit),
        .o_golden    (w_golden),
        .o_sum       (w_sum)
    );

    assign w_active        = (r_state == ST_APPLY) || (r_state == ST_SETTLE) || (r_state == ST_EMIT);
    assign w_first_in      = find_mode(mode_mask, 3'd0);
    assign w_first_latched = find_mode(r_mask, 3'd0);
    assign w_next_mode     = find_mode(r_mask, {1'b0, r_mode} + 3'd1);
    // Abort wins over a same-cycle handshake, so a dropped record is never counted.
    assign w_handshake     = (r_state == ST_EMIT) && rec_ready && !w_abort;
    assign w_last          = (r_a == '1) && (r_b == '1) && !w_next_mode[2];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; abort overrides every active-state transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = (mode_mask == '0) ? ST_DONE : ST_APPLY;
            ST_APPLY:  w_state_next = (SETTLE == 0) ? ST_EMIT : ST_SETTLE;
            ST_SETTLE: if (r_settle_cnt == SCW'(SETTLE - 1)) w_state_next = ST_EMIT;
            ST_EMIT:   if (rec_ready) w_state_next = w_last ? ST_DONE : ST_APPLY;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
        if (w_abort && w_active) begin
            w_state_next = ST_DONE;
        end
    end

    // Counters, latched configuration, record registers and mismatch total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask         <= '0;
            r_fault_bit    <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_mode         <= MODE_NONE;
            r_settle_cnt   <= '0;
            r_done         <= 1'b0;
            r_rec_a        <= '0;
            r_rec_b        <= '0;
            r_rec_mode     <= MODE_NONE;
            r_rec_sum      <= '0;
            r_rec_golden   <= '0;
            r_rec_mismatch <= 1'b0;
            r_mismatch_cnt <= '0;
        end else begin
            // done trails the one-cycle DONE state by a register stage.
            r_done <= (r_state == ST_DONE);
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mask         <= mode_mask;
                        r_fault_bit    <= fault_bit;
                        r_mismatch_cnt <= '0;
                        r_a            <= '0;
                        r_b            <= '0;
                        r_mode         <= fault_mode_e'(w_first_in[1:0]);
                        r_settle_cnt   <= '0;
                    end
                end
                ST_APPLY:  r_settle_cnt <= '0;
                ST_SETTLE: r_settle_cnt <= r_settle_cnt + 1'b1;
                ST_EMIT: begin
                    if (w_handshake) begin
                        r_mismatch_cnt <= r_mismatch_cnt + CW'(r_rec_mismatch);
                        // mode innermost, then b, then a.
                        if (w_next_mode[2]) begin
                            r_mode <= fault_mode_e'(w_next_mode[1:0]);
                        end else begin
                            r_mode <= fault_mode_e'(w_first_latched[1:0]);
                            if (r_b == '1) begin
                                r_b <= '0;
                                r_a <= r_a + 1'b1;
                            end else begin
                                r_b <= r_b + 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
            if ((w_state_next == ST_EMIT) && (r_state != ST_EMIT)) begin
                r_rec_a        <= r_a;
                r_rec_b        <= r_b;
                r_rec_mode     <= r_mode;
                r_rec_sum      <= w_sum;
                r_rec_golden   <= w_golden;
                r_rec_mismatch <= (w_sum != w_golden);
            end
        end
    end

    assign busy         = w_active;
    assign done         = r_done;
    assign rec_valid    = (r_state == ST_EMIT);
    assign rec_a        = r_rec_a;
    assign rec_b        = r_rec_b;
    assign rec_mode     = r_rec_mode;
    assign rec_sum      = r_rec_sum;
    assign rec_golden   = r_rec_golden;
    assign rec_mismatch = r_rec_mismatch;
    assign mismatch_cnt = r_mismatch_cnt;

endmodule

// File: tb/tb_adder_fault_sweep.sv
// Scoreboard bench for adder_fault_sweep (WIDTH=2, SETTLE=1). Stimulus
// pushes expected records from an arithmetic model; a monitor pops and
// compares on every accepted record. The abort checks are included when
// ADDER_FAULT_SWEEP_ABORT_EN is defined.
module tb_adder_fault_sweep;

    localparam int W   = 2;
    localparam int FBW = $clog2(W + 2);

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   mode;
        logic [W:0]   sum;
        logic [W:0]   golden;
        logic         mm;
    } rec_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [3:0]       mode_mask;
    logic [FBW-1:0]   fault_bit;
    logic             busy, done, rec_valid, rec_ready;
    logic [W-1:0]     rec_a, rec_b;
    logic [1:0]       rec_mode;
    logic [W:0]       rec_sum, rec_golden;
    logic             rec_mismatch;
    logic [2*W+2:0]   mismatch_cnt;
`ifdef ADDER_FAULT_SWEEP_ABORT_EN
    logic             abort;
`endif

    rec_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   n_pop    = 0;
    int   mm_acc   = 0;
    int   done_total = 0;
    int   hold_seen  = 0;
    bit   hold_en    = 1'b0;
    bit   rand_ready = 1'b0;

    always #5 clk = ~clk;

    adder_fault_sweep #(.WIDTH(W), .SETTLE(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode_mask    (mode_mask),
        .fault_bit    (fault_bit),
`ifdef ADDER_FAULT_SWEEP_ABORT_EN
        .abort        (abort),
`endif
        .busy         (busy),
        .done         (done),
        .rec_valid    (rec_valid),
        .rec_ready    (rec_ready),
        .rec_a        (rec_a),
        .rec_b        (rec_b),
        .rec_mode     (rec_mode),
        .rec_sum      (rec_sum),
        .rec_golden   (rec_golden),
        .rec_mismatch (rec_mismatch),
        .mismatch_cnt (mismatch_cnt)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: enumerate a (outer), b, enabled modes (inner) and
    // corrupt the chosen bit of the full-width sum arithmetically.
    task automatic push_model(input logic [3:0] mask, input int fb, output int exp_mm);
        rec_t r;
        int   g, s;
        exp_mm = 0;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                for (int m = 0; m < 4; m++) begin
                    if (mask[m]) begin
                        g = a + b;
                        s = g;
                        if (fb <= W) begin
                            if (m == 1) s = g & ~(1 << fb);
                            if (m == 2) s = g | (1 << fb);
                            if (m == 3) s = g ^ (1 << fb);
                        end
                        r.a      = a[W-1:0];
                        r.b      = b[W-1:0];
                        r.mode   = m[1:0];
                        r.sum    = s[W:0];
                        r.golden = g[W:0];
                        r.mm     = (s != g);
                        exp_mm  += int'(r.mm);
                        q.push_back(r);
                    end
                end
            end
        end
    endtask

    // Ready driver: always high, random, or a 5-cycle stall on one record.
    initial begin
        rec_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_en && rec_valid && rec_a == W'(1) && rec_b == W'(2) &&
                rec_mode == 2'd3 && hold_seen < 5)
                rec_ready = 1'b0;
            else if (rand_ready)
                rec_ready = ($urandom_range(0, 3) != 0);
            else
                rec_ready = 1'b1;
        end
    end

    // Monitor: compare each accepted record and check stability under stall.
    initial begin
        rec_t cur, prev, e;
        bit   stalled;
        stalled = 1'b0;
        prev    = '0;
        forever begin
            @(negedge clk);
            if (done) done_total++;
            if (rst_n && rec_valid) begin
                cur = {rec_a, rec_b, rec_mode, rec_sum, rec_golden, rec_mismatch};
                if (stalled) begin
                    n_checks++;
                    if (cur !== prev) begin
                        n_err++;
                        $display("FAIL rec_stable: actual=%h required=%h", cur, prev);
                    end
                end
                if (rec_ready) begin
                    n_checks++;
                    if (q.size() == 0) begin
                        n_err++;
                        $display("FAIL rec_extra: actual=%h required=none", cur);
                    end else begin
                        e = q.pop_front();
                        if (cur !== e) begin
                            n_err++;
                            $display("FAIL rec: actual=%h required=%h", cur, e);
                        end
                        mm_acc += int'(e.mm);
                        n_pop++;
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    prev    = cur;
                    if (hold_en && cur.a == W'(1) && cur.b == W'(2) && cur.mode == 2'd3)
                        hold_seen++;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // One full sweep; optionally checks start-to-output latency.
    task automatic run_sweep(input logic [3:0] mask, input int fb, input bit chk_lat);
        int exp_mm, cyc, dbase;
        @(posedge clk);
        #1;
        push_model(mask, fb, exp_mm);
        dbase     = done_total;
        mode_mask = mask;
        fault_bit = fb[FBW-1:0];
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (chk_lat) begin
            @(negedge clk);
            check("lat_n0_valid", rec_valid, 0);
            check("lat_n0_busy", busy, (mask != 0));
            check("lat_n0_done", done, 0);
            @(negedge clk);
            check("lat_n1_valid", rec_valid, 0);
            check("lat_n1_done", done, (mask == 0));
            if (mask != 0) begin
                @(negedge clk);
                check("lat_n2_valid", rec_valid, 1);
            end
        end
        cyc = 0;
        while ((done_total - dbase) == 0 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check("sweep_timeout", (cyc < 3000), 1);
        check("mismatch_cnt", mismatch_cnt, exp_mm);
        check("queue_drained", q.size(), 0);
        check("busy_after", busy, 0);
        repeat (2) @(negedge clk);
        check("done_once", done_total - dbase, 1);
        check("mismatch_hold", mismatch_cnt, exp_mm);
        $display("sweep mask=%b fault_bit=%0d mismatch_cnt=%0d expected=%0d", mask, fb,
                 mismatch_cnt, exp_mm);
        q.delete();
    endtask

    // Hard stop in case a wait is never satisfied.
    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int tmp, acc_base, pop_base, cyc;
        rst_n     = 1'b0;
        start     = 1'b0;
        mode_mask = '0;
        fault_bit = '0;
`ifdef ADDER_FAULT_SWEEP_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {busy, done, rec_valid, rec_mismatch, rec_a, rec_b, rec_mode,
                             rec_sum, rec_golden}, 0);
        check("reset_cnt", mismatch_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_sweep(4'b1111, 0, 1'b0);
        run_sweep(4'b0001, $urandom_range(0, 3), 1'b1);
        run_sweep(4'b0000, 1, 1'b1);
        run_sweep(4'b1110, 3, 1'b0);

        hold_en = 1'b1;
        run_sweep(4'b1000, 2, 1'b0);
        check("hold_cycles", hold_seen, 5);
        hold_en = 1'b0;

        rand_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_sweep(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b0);
        end
        rand_ready = 1'b0;

        // Reset in the middle of a sweep, then rerun from a=0, b=0.
        @(posedge clk);
        #1;
        push_model(4'b1111, 1, tmp);
        mode_mask = 4'b1111;
        fault_bit = FBW'(1);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {busy, done, rec_valid, rec_mismatch, rec_a, rec_b, rec_mode,
                              rec_sum, rec_golden}, 0);
        check("midrst_cnt", mismatch_cnt, 0);
        q.delete();
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("reset applied mid-sweep, rerunning");
        run_sweep(4'b1111, 1, 1'b0);

`ifdef ADDER_FAULT_SWEEP_ABORT_EN
        // Abort while settling after the fifth accepted record.
        @(posedge clk);
        #1;
        push_model(4'b1111, 0, tmp);
        acc_base  = mm_acc;
        pop_base  = n_pop;
        mode_mask = 4'b1111;
        fault_bit = '0;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            cyc++;
        end while ((n_pop - pop_base) < 5 && cyc < 500);
        check("abort_wait", (cyc < 500), 1);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_stop", {busy, rec_valid}, 0);
        @(negedge clk);
        check("abort_done", done, 1);
        check("abort_cnt", mismatch_cnt, mm_acc - acc_base);
        check("abort_pops", n_pop - pop_base, 5);
        q.delete();
        repeat (3) @(negedge clk);
        check("abort_hold", mismatch_cnt, mm_acc - acc_base);
        $display("abort after 5 records mismatch_cnt=%0d", mismatch_cnt);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
